vga_rect_fill: RTL
==================

// Module: vga_rect_fill
// PURPOSE
//   Pixel-write generator feeding the VGA top's framebuffer write port (color/addr_x/addr_y/we).
//   Accepts rectangle-fill commands over a valid/ready handshake, normalises and clips them to
//   the HD x VD screen, then emits one pixel write per accepted cycle in raster order.
//   Used for clear-screen (full-screen rect) and UI box drawing.
// PARAMETERS
//   X_BITS      11    width of x coordinates
//   Y_BITS      11    width of y coordinates
//   HD          1280  visible width; legal x is 0..HD-1
//   VD          1024  visible height; legal y is 0..VD-1
//   COLOR_BITS  2     pixel colour code width (0 BLACK, 1 WHITE, 2 BLUE, 3 GREEN)
// PORTS
//   clk_i        in   1              system clock (one clock; rising edge)
//   arstn_i      in   1              asynchronous, active-low reset
//   cmd_valid_i  in   1              command valid
//   cmd_ready_o  out  1              command accepted when valid&ready
//   cmd_x0_i     in   X_BITS         corner A x
//   cmd_y0_i     in   Y_BITS         corner A y
//   cmd_x1_i     in   X_BITS         corner B x
//   cmd_y1_i     in   Y_BITS         corner B y
//   cmd_color_i  in   COLOR_BITS     fill colour
//   pix_ready_i  in   1              sink accepts current write this cycle
//   we_o         out  1              pixel write valid
//   addr_x_o     out  X_BITS         pixel x
//   addr_y_o     out  Y_BITS         pixel y
//   color_o      out  COLOR_BITS     pixel colour
//   busy_o       out  1              state != IDLE
//   done_o       out  1              1-cycle pulse: command finished
//   pix_count_o  out  X_BITS+Y_BITS  writes accepted for current/last command
// BEHAVIOUR
//   Reset: state IDLE; cmd_ready_o=1; we_o, busy_o, done_o=0; addr/colour/pix_count_o=0.
//   Reset asserted mid-command: command discarded, no further writes, same values as above.
//   FSM IDLE -> CLIP -> FILL -> DONE -> IDLE (CLIP -> DONE if clipped rect empty).
//   IDLE: cmd_ready_o=1 only here. On valid&ready (cycle T) register corners+colour,
//     clear pix_count_o, go CLIP. cmd_valid_i in any other state is ignored (not stored).
//   CLIP (T+1): xs=min(x0,x1), xe=max(x0,x1), same for y; unsigned compare.
//     If xs>=HD or ys>=VD -> empty, go DONE. Else xe=min(xe,HD-1), ye=min(ye,VD-1);
//     load addr_x_o=xs, addr_y_o=ys; go FILL.
//   FILL: we_o=1 from T+2. Write is transferred when we_o&pix_ready_i; then pix_count_o+=1.
//     While pix_ready_i=0, we_o/addr/colour held stable (no change, no drop).
//     Advance: if addr_x_o<xe, x+=1; else x=xs and y+=1. Transfer at (xe,ye) -> DONE.
//     Coordinates never exceed xe/ye; no wrap beyond the clipped box.
//   DONE: we_o=0, done_o=1 for exactly one cycle, pix_count_o holds final value -> IDLE.
//   Fill with pix_ready_i held 1: N=(xe-xs+1)*(ye-ys+1) writes on T+2..T+N+1, done_o at T+N+2,
//     cmd_ready_o=1 again at T+N+3. Next command may be accepted that cycle (back-to-back).
//   Single-pixel rect (x0=x1, y0=y1): one write, done_o at T+3.
//   Full screen (0,0)-(HD-1,VD-1): HD*VD writes; pix_count_o must not overflow.
//   color_o constant for a whole command; equals cmd_color_i sampled at T.
// TESTING
//   1 Cmd (10,20)-(11,21) col 2, pix_ready=1 -> writes (10,20),(11,20),(10,21),(11,21) on
//     T+2..T+5, color_o=2, done_o at T+6, pix_count_o=4.
//   2 Swapped corners (11,21)-(10,20) -> identical write sequence and timing as test 1.
//   3 Clip (1270,1020)-(1300,1030) -> 40 writes, last at (1279,1023), none with x>1279/y>1023.
//   4 Off-screen (1280,0)-(1290,5) -> zero writes, done_o at T+2, pix_count_o=0.
//   5 Backpressure: test 1 with pix_ready_i=1,0,0,1,0,1,1 -> outputs stable during stalls,
//     same 4 addresses, done_o 1 cycle after last transfer; cmd_valid_i while busy ignored.
//   6 arstn_i low during FILL after 2 writes -> we_o/busy_o drop immediately, IDLE, ready=1;
//     fresh command afterwards runs normally from its own first pixel.

Source files
------------

// File: rtl/vga_rect_fill.sv
// Rectangle-fill pixel write generator: normalises and clips a box to the screen, then walks it in raster order.
// Latency: first write two cycles after command accept, then one write per accepted cycle; done pulse one cycle after the last write.
// Backpressure: pix_ready_i low holds the current write stable; new commands are accepted only while idle.
module vga_rect_fill #(
    parameter int X_BITS     = 11,
    parameter int Y_BITS     = 11,
    parameter int HD         = 1280,
    parameter int VD         = 1024,
    parameter int COLOR_BITS = 2
) (
    input  logic                     clk_i,
    input  logic                     arstn_i,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic [X_BITS-1:0]        cmd_x0_i,
    input  logic [Y_BITS-1:0]        cmd_y0_i,
    input  logic [X_BITS-1:0]        cmd_x1_i,
    input  logic [Y_BITS-1:0]        cmd_y1_i,
    input  logic [COLOR_BITS-1:0]    cmd_color_i,
    input  logic                     pix_ready_i,
    output logic                     we_o,
    output logic [X_BITS-1:0]        addr_x_o,
    output logic [Y_BITS-1:0]        addr_y_o,
    output logic [COLOR_BITS-1:0]    color_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [X_BITS+Y_BITS-1:0] pix_count_o
);

    localparam int PC_W = X_BITS + Y_BITS;

    // Screen limits widened by one bit so HD/VD themselves are representable.
    localparam logic [X_BITS:0]   HD_W  = (X_BITS + 1)'(HD);
    localparam logic [Y_BITS:0]   VD_W  = (Y_BITS + 1)'(VD);
    localparam logic [X_BITS-1:0] X_MAX = X_BITS'(HD - 1);
    localparam logic [Y_BITS-1:0] Y_MAX = Y_BITS'(VD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLIP = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;

    // Raw corners as captured at accept time.
    logic [X_BITS-1:0] x0_q, x1_q;
    logic [Y_BITS-1:0] y0_q, y1_q;

    // Clipped box bounds used while filling.
    logic [X_BITS-1:0] xs_q, xe_q;
    logic [Y_BITS-1:0] ye_q;

    logic [X_BITS-1:0] xs_c, xe_c, xe_clip;
    logic [Y_BITS-1:0] ys_c, ye_c, ye_clip;
    logic              empty_c;
    logic              x_last, y_last;

    // Normalise corners and clip the far edge to the visible area.
    always_comb begin
        xs_c    = (x0_q < x1_q) ? x0_q : x1_q;
        xe_c    = (x0_q < x1_q) ? x1_q : x0_q;
        ys_c    = (y0_q < y1_q) ? y0_q : y1_q;
        ye_c    = (y0_q < y1_q) ? y1_q : y0_q;
        empty_c = ({1'b0, xs_c} >= HD_W) || ({1'b0, ys_c} >= VD_W);
        xe_clip = (xe_c > X_MAX) ? X_MAX : xe_c;
        ye_clip = (ye_c > Y_MAX) ? Y_MAX : ye_c;
        x_last  = (addr_x_o == xe_q);
        y_last  = (addr_y_o == ye_q);
    end

    // Command FSM with registered handshake, pixel and status outputs.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state       <= IDLE;
            cmd_ready_o <= 1'b1;
            we_o        <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            addr_x_o    <= '0;
            addr_y_o    <= '0;
            color_o     <= '0;
            pix_count_o <= '0;
            x0_q        <= '0;
            x1_q        <= '0;
            y0_q        <= '0;
            y1_q        <= '0;
            xs_q        <= '0;
            xe_q        <= '0;
            ye_q        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_o <= 1'b0;
                    if (cmd_valid_i) begin
                        x0_q        <= cmd_x0_i;
                        y0_q        <= cmd_y0_i;
                        x1_q        <= cmd_x1_i;
                        y1_q        <= cmd_y1_i;
                        color_o     <= cmd_color_i;
                        pix_count_o <= '0;
                        cmd_ready_o <= 1'b0;
                        busy_o      <= 1'b1;
                        state       <= CLIP;
                    end
                end
                CLIP: begin
                    if (empty_c) begin
                        done_o <= 1'b1;
                        state  <= DONE;
                    end else begin
                        xs_q     <= xs_c;
                        xe_q     <= xe_clip;
                        ye_q     <= ye_clip;
                        addr_x_o <= xs_c;
                        addr_y_o <= ys_c;
                        we_o     <= 1'b1;
                        state    <= FILL;
                    end
                end
                FILL: begin
                    if (pix_ready_i) begin
                        pix_count_o <= pix_count_o + PC_W'(1);
                        if (x_last) begin
                            if (y_last) begin
                                we_o   <= 1'b0;
                                done_o <= 1'b1;
                                state  <= DONE;
                            end else begin
                                addr_x_o <= xs_q;
                                addr_y_o <= addr_y_o + Y_BITS'(1);
                            end
                        end else begin
                            addr_x_o <= addr_x_o + X_BITS'(1);
                        end
                    end
                end
                DONE: begin
                    done_o      <= 1'b0;
                    busy_o      <= 1'b0;
                    cmd_ready_o <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
